multicycle_control: RTL and testbench

Multi-cycle sequencer for the Simple_CPU datapath. It replaces single-cycle opcode decode with a Moore state machine that steps one instruction through fetch, decode, execute, memory and writeback over several clocks. It drives the shared ALU, the unified instruction/data memory port, the IR, the PC and the register file. It supports the R-type, beq, lw, sw and j opcodes, plus a wait-state handshake with memory.

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/mc_output_decode.sv | 85 ++++++++
 rtl/multicycle_control.sv | 98 +++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the Simple_CPU multi-cycle control.
// State, opcode, ALU and mux-select codes plus the control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_TRAP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_LW) || (op == OP_SW) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, instr_done, illegal,
    output state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, instr_done, illegal,
    input  state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output map: state (+ mem_ready in wait states) -> controls.
// MC_ILLEGAL_TRAP_EN selects trap vs. NOP handling of bad opcodes.
module mc_output_decode
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  state_t i_state,
  input  logic   i_mem_ready,
`ifndef MC_ILLEGAL_TRAP_EN
  input  logic   i_op_illegal,
`endif
  output ctrl_t  o_ctrl
);

  logic w_ready;
  assign w_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      ST_IDLE: ;
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ir_write  = w_ready;
        o_ctrl.pc_write  = w_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
`ifndef MC_ILLEGAL_TRAP_EN
        // unsupported opcode retires here as a NOP
        o_ctrl.instr_done = i_op_illegal;
`endif
      end
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = w_ready;
      end
      ST_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      ST_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        o_ctrl.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for Simple_CPU (R-type, beq, lw, sw, j).
// Optional MC_ILLEGAL_TRAP_EN: bad opcodes lock in TRAP until reset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_ready;

  assign w_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

`ifndef MC_ILLEGAL_TRAP_EN
  logic w_op_illegal;
  assign w_op_illegal = !op_legal(bus.op);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: if (w_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        if (bus.op == OP_RTYPE)
          w_next = ST_EXECUTE;
        else if (bus.op == OP_BEQ)
          w_next = ST_BRANCH;
        else if (bus.op == OP_LW || bus.op == OP_SW)
          w_next = ST_MEM_ADDR;
        else if (bus.op == OP_J)
          w_next = ST_JUMP;
        else
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = ST_TRAP;
`else
          w_next = ST_FETCH;
`endif
      end
      ST_MEM_ADDR:
        w_next = (bus.op == OP_SW) ? ST_MEM_WRITE
                                   : ST_MEM_READ;
      ST_MEM_READ:  if (w_ready) w_next = ST_MEM_WB;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WRITE: if (w_ready) w_next = ST_FETCH;
      ST_EXECUTE:   w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:      w_next = ST_TRAP;
`else
      ST_TRAP:      w_next = ST_IDLE;
`endif
      default:      w_next = ST_IDLE;
    endcase
  end

  mc_output_decode #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE)
  ) u_dec (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
`ifndef MC_ILLEGAL_TRAP_EN
    .i_op_illegal(w_op_illegal),
`endif
    .o_ctrl      (w_ctrl)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.instr_done    = w_ctrl.instr_done;
  assign bus.illegal       = w_ctrl.illegal;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; state/control tables per cycle.
// Build with +define+MC_ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Field order: pcw pcwc iod mr mw irw | m2r rd rw asa | asb | aop | psrc | done ill
  localparam logic [17:0] E_ZERO   = 18'b000000_0000_00_00_00_00;
  localparam logic [17:0] E_FETCH  = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] E_DECODE = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] E_DECNOP = 18'b000000_0000_11_00_00_10;
  localparam logic [17:0] E_EXEC   = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] E_RWB    = 18'b000000_0110_00_00_00_10;
  localparam logic [17:0] E_MADDR  = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] E_MREAD  = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] E_MWB    = 18'b000000_1010_00_00_00_10;
  localparam logic [17:0] E_MWR    = 18'b001010_0000_00_00_00_10;
  localparam logic [17:0] E_BR     = 18'b010000_0001_00_01_01_10;
  localparam logic [17:0] E_JMP    = 18'b100000_0000_00_00_10_10;
  localparam logic [17:0] E_TRAP   = 18'b000000_0000_00_00_00_01;

  function automatic logic [17:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.instr_done, bus.illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.op = 6'd0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want 0", bus.state);
    end
    n_checks++;
    if (outs() !== E_ZERO) begin
      n_fail++;
      $display("FAIL reset_outs: got %b, want %b", outs(), E_ZERO);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %0d, want 0", bus.state);
    end
    tick();
  endtask

  task automatic test_rtype();
    int st[5] = '{1, 2, 7, 8, 1};
    logic [17:0] ex[5] = '{E_FETCH, E_DECODE, E_EXEC, E_RWB, E_FETCH};
    int dones = 0;
    bus.op = 6'd0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL rtype step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 4) begin
        if (bus.instr_done === 1'b1) dones++;
        tick();
      end
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL rtype_done_count: got %0d, want 1", dones);
    end
  endtask

  task automatic test_lw_wait();
    int st[7] = '{1, 2, 3, 4, 4, 5, 1};
    logic rdy[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] ex[7] = '{E_FETCH, E_DECODE, E_MADDR, E_MREAD,
                           E_MREAD, E_MWB, E_FETCH};
    bus.op = 6'd35;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL lw_wait step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8] = '{6'd43, 6'd43, 6'd43, 6'd43, 6'd4, 6'd4, 6'd4, 6'd4};
    int st[8] = '{1, 2, 3, 6, 1, 2, 9, 1};
    logic [17:0] ex[8] = '{E_FETCH, E_DECODE, E_MADDR, E_MWR,
                           E_FETCH, E_DECODE, E_BR, E_FETCH};
    int dones = 0;
    int mws = 0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.op = ops[i];
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL sw_beq step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 7) begin
        if (bus.instr_done === 1'b1) dones++;
        if (bus.mem_write === 1'b1) mws++;
        tick();
      end
    end
    n_checks++;
    if (dones !== 2) begin
      n_fail++;
      $display("FAIL sw_beq_done_count: got %0d, want 2", dones);
    end
    n_checks++;
    if (mws !== 1) begin
      n_fail++;
      $display("FAIL sw_mem_write_cycles: got %0d, want 1", mws);
    end
  endtask

  task automatic test_jump();
    int st[4] = '{1, 2, 10, 1};
    logic [17:0] ex[4] = '{E_FETCH, E_DECODE, E_JMP, E_FETCH};
    bus.op = 6'd2;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL jump step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_reset_mid_lw();
    int st[4] = '{1, 2, 3, 4};
    logic rdy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [17:0] ex[4] = '{E_FETCH, E_DECODE, E_MADDR, E_MREAD};
    bus.op = 6'd35;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL rst_lw step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 3) tick();
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || outs() !== E_ZERO) begin
      n_fail++;
      $display("FAIL rst_lw_async: state=%0d ctl=%b, want state=0 ctl=%b",
               bus.state, outs(), E_ZERO);
    end
    bus.mem_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || outs() !== E_ZERO) begin
      n_fail++;
      $display("FAIL rst_lw_held: state=%0d ctl=%b, want state=0 ctl=%b",
               bus.state, outs(), E_ZERO);
    end
    rst_n = 1'b1;
    tick();
    #1;
    n_checks++;
    if (bus.state !== 4'd1 || outs() !== E_FETCH) begin
      n_fail++;
      $display("FAIL rst_lw_refetch: state=%0d ctl=%b, want state=1 ctl=%b",
               bus.state, outs(), E_FETCH);
    end
  endtask

`ifdef MC_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    int st;
    logic [17:0] ex;
    bus.op = 6'd63;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      st = (i == 0) ? 1 : (i == 1) ? 2 : 11;
      ex = (i == 0) ? E_FETCH : (i == 1) ? E_DECODE : E_TRAP;
      bus.mem_ready = i[0];
      if (i == 0) bus.mem_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.state !== st || outs() !== ex) begin
        n_fail++;
        $display("FAIL illegal_trap step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st, ex);
      end
      if (i < 11) tick();
    end
  endtask
`else
  task automatic test_illegal();
    int st[3] = '{1, 2, 1};
    logic [17:0] ex[3] = '{E_FETCH, E_DECNOP, E_FETCH};
    bus.op = 6'd63;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL illegal_nop step %0d: state=%0d ctl=%b, want state=%0d ctl=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      if (i < 2) tick();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_jump();
    test_reset_mid_lw();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
